// File: rtl/saradc_avg_fifo.sv
// Averages groups of 2^LOG2_AVG SAR ADC conversions and queues the results
// in a small first-word-fall-through FIFO popped with a valid/ready handshake.
module saradc_avg_fifo #(
   parameter int DW         = 10,
   parameter int LOG2_AVG   = 2,
   parameter int LOG2_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic [DW-1:0]         adc_result,
   input  logic                  adc_valid,
   output logic [DW-1:0]         avg_data,
   output logic                  avg_valid,
   input  logic                  avg_ready,
   output logic [LOG2_DEPTH:0]   fifo_count,
   output logic                  overflow,
   input  logic                  clr_ovf
);

   localparam int ACC_W = DW + LOG2_AVG;
   localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
   localparam logic [LOG2_DEPTH:0]   CNT_FULL = (LOG2_DEPTH+1)'(DEPTH);

   function automatic logic [DW-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
      return sum[ACC_W-1:LOG2_AVG];
   endfunction

   logic                  r_adc_valid_q;
   logic [ACC_W-1:0]      r_acc;
   logic [CNT_W-1:0]      r_cnt;
   logic [DW-1:0]         r_mem [DEPTH];
   logic [LOG2_DEPTH-1:0] r_wr_ptr;
   logic [LOG2_DEPTH-1:0] r_rd_ptr;
   logic [LOG2_DEPTH:0]   r_count;
   logic                  r_overflow;

   logic                  w_sample_evt;
   logic                  w_last;
   logic [ACC_W-1:0]      w_sum;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_en;
   logic                  w_drop;

   assign w_sample_evt = adc_valid & ~r_adc_valid_q & enable;
   assign w_last       = (r_cnt == CNT_LAST);
   assign w_sum        = r_acc + {{LOG2_AVG{1'b0}}, adc_result};
   assign w_push       = w_sample_evt & w_last;

   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);
   assign w_pop   = ~w_empty & avg_ready;
   // A push into a full FIFO only lands when the same cycle frees a slot.
   assign w_wr_en = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   // Sample detect and accumulation
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_adc_valid_q <= 1'b0;
         r_acc         <= '0;
         r_cnt         <= '0;
      end else begin
         r_adc_valid_q <= adc_valid;
         if (!enable) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (w_sample_evt) begin
            if (w_last) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= avg_trunc(w_sum);
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr_en && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_wr_en) r_count <= r_count - 1'b1;
         if (w_drop)       r_overflow <= 1'b1;
         else if (clr_ovf) r_overflow <= 1'b0;
      end
   end

   // Head is forced to zero when empty so stale memory never shows after reset.
   assign avg_valid  = ~w_empty;
   assign avg_data   = w_empty ? '0 : r_mem[r_rd_ptr];
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_saradc_avg_fifo.sv
// Directed bench for saradc_avg_fifo with hand-computed averages.
module tb_saradc_avg_fifo;

   logic       clk = 1'b0;
   logic       rstn;
   logic       enable;
   logic [9:0] adc_result;
   logic       adc_valid;
   logic [9:0] avg_data;
   logic       avg_valid;
   logic       avg_ready;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       clr_ovf;

   int n_vec = 0;
   int n_err = 0;

   saradc_avg_fifo #(.DW(10), .LOG2_AVG(2), .LOG2_DEPTH(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .enable     (enable),
      .adc_result (adc_result),
      .adc_valid  (adc_valid),
      .avg_data   (avg_data),
      .avg_valid  (avg_valid),
      .avg_ready  (avg_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input int v);
      adc_result = 10'(v);
      adc_valid  = 1'b1;
      step();
      adc_valid  = 1'b0;
      step();
   endtask

   task automatic send_avg(input int v);
      for (int i = 0; i < 4; i++) send_sample(v);
   endtask

   task automatic pop_chk(input string tag, input int exp);
      chk({tag, "_valid"}, int'(avg_valid), 1);
      chk({tag, "_data"}, int'(avg_data), exp);
      avg_ready = 1'b1;
      step();
      avg_ready = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; enable = 1'b0; adc_result = '0; adc_valid = 1'b0;
      avg_ready = 1'b0; clr_ovf = 1'b0;
      step(); step();
      chk("rst_valid", int'(avg_valid), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_data", int'(avg_data), 0);
      rstn = 1'b1; enable = 1'b1;
      step();

      // T1: 100..103 -> 101, visible one cycle after the 4th edge
      send_sample(100); send_sample(101); send_sample(102);
      adc_result = 10'd103; adc_valid = 1'b1;
      chk("t1_pre_valid", int'(avg_valid), 0);
      step();
      chk("t1_valid", int'(avg_valid), 1);
      chk("t1_data", int'(avg_data), 101);
      chk("t1_count", int'(fifo_count), 1);
      adc_valid = 1'b0;
      step();
      pop_chk("t1_pop", 101);
      chk("t1_empty", int'(avg_valid), 0);

      // T2: full scale and truncation
      send_avg(1023);
      pop_chk("t2_max", 1023);
      send_sample(0); send_sample(0); send_sample(0); send_sample(3);
      pop_chk("t2_trunc", 0);

      // T3: a held level counts once
      adc_result = 10'd10; adc_valid = 1'b1;
      for (int i = 0; i < 10; i++) step();
      adc_valid = 1'b0;
      step();
      send_sample(20); send_sample(30);
      chk("t3_partial", int'(fifo_count), 0);
      send_sample(40);
      chk("t3_count", int'(fifo_count), 1);
      pop_chk("t3_avg", 25);
      chk("t3_empty", int'(fifo_count), 0);

      // T4: overflow on 5th average, order preserved, clear
      send_avg(10); send_avg(20); send_avg(30); send_avg(40);
      chk("t4_ovf_pre", int'(overflow), 0);
      send_avg(50);
      chk("t4_count", int'(fifo_count), 4);
      chk("t4_ovf", int'(overflow), 1);
      pop_chk("t4_p1", 10);
      pop_chk("t4_p2", 20);
      pop_chk("t4_p3", 30);
      pop_chk("t4_p4", 40);
      chk("t4_empty", int'(avg_valid), 0);
      chk("t4_ovf_sticky", int'(overflow), 1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t4_ovf_clr", int'(overflow), 0);

      // T5: enable low discards partial sum
      send_sample(7); send_sample(7);
      enable = 1'b0;
      step();
      enable = 1'b1;
      send_avg(200);
      chk("t5_count", int'(fifo_count), 1);
      pop_chk("t5_avg", 200);

      // Push into empty with ready asserted: pop ignored
      send_sample(8); send_sample(8); send_sample(8);
      adc_result = 10'd8; adc_valid = 1'b1; avg_ready = 1'b1;
      step();
      adc_valid = 1'b0; avg_ready = 1'b0;
      chk("pe_count", int'(fifo_count), 1);
      chk("pe_data", int'(avg_data), 8);
      step();
      pop_chk("pe_pop", 8);

      // T6: full + push + pop in same cycle
      send_avg(1); send_avg(2); send_avg(3); send_avg(4);
      chk("t6_full", int'(fifo_count), 4);
      send_sample(5); send_sample(5); send_sample(5);
      adc_result = 10'd5; adc_valid = 1'b1; avg_ready = 1'b1;
      step();
      adc_valid = 1'b0; avg_ready = 1'b0;
      chk("t6_count", int'(fifo_count), 4);
      chk("t6_ovf", int'(overflow), 0);
      step();
      pop_chk("t6_p1", 2);
      pop_chk("t6_p2", 3);
      pop_chk("t6_p3", 4);
      pop_chk("t6_p4", 5);
      chk("t6_empty", int'(fifo_count), 0);

      // T6b: reset mid-group
      send_avg(33);
      send_sample(9); send_sample(9);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("t6r_valid", int'(avg_valid), 0);
      chk("t6r_count", int'(fifo_count), 0);
      chk("t6r_ovf", int'(overflow), 0);
      chk("t6r_data", int'(avg_data), 0);
      send_sample(60); send_sample(60); send_sample(60);
      chk("t6r_partial", int'(fifo_count), 0);
      send_sample(60);
      chk("t6r_count2", int'(fifo_count), 1);
      pop_chk("t6r_avg", 60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
